// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader (state encoding, widths, defaults).
// No logic, no latency. PROG_LOADER_CSUM_EN adds the checksum state to the encoding.
// Backpressure: not applicable.
package prog_loader_pkg;
    localparam int ADDR_W = 4;
    localparam int WORD_W = 8;
    localparam int DEPTH_DEF = 16;
    localparam logic [WORD_W-1:0] MAGIC_DEF = 8'hA5;

`ifdef PROG_LOADER_CSUM_EN
    typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, CSUM, RUN, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, RUN, ERR} state_t;
`endif
endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream load port plus CPU fetch port of the program loader.
// No logic, no latency; master drives stream and fetch address, slave is the loader.
// Backpressure: in_ready from the slave qualifies each in_valid byte.
interface prog_loader_if;
    import prog_loader_pkg::*;

    logic              start;
    logic              in_valid;
    logic [WORD_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic [WORD_W-1:0] cpu_instr;
    logic              cpu_run;
    logic              busy;
    logic              error;

    modport master (
        output start, in_valid, in_data, cpu_addr,
        input  in_ready, cpu_instr, cpu_run, busy, error
    );

    modport slave (
        input  start, in_valid, in_data, cpu_addr,
        output in_ready, cpu_instr, cpu_run, busy, error
    );
endinterface

// File: rtl/prog_mem.sv
// DEPTH x 8 program store: one synchronous write port, one asynchronous read port.
// Write lands on the next rising edge; read is combinational.
// Backpressure: none, a write is taken every cycle wrEn is high.
module prog_mem
    import prog_loader_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [WORD_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [WORD_W-1:0] rdData
);
    logic [WORD_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; the loader masks stale words via its length.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    assign rdData = mem[rdAddr];
endmodule

// File: rtl/prog_loader.sv
// Loads a MAGIC/length/data[/checksum] byte image into program memory and releases the CPU.
// cpu_run rises one cycle after the final accepted byte; cpu_instr is combinational.
// Backpressure: in_ready high only while loading; PROG_LOADER_CSUM_EN enables the checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int                DEPTH = DEPTH_DEF,
    parameter logic [WORD_W-1:0] MAGIC = MAGIC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    prog_loader_if.slave  bus
);
    localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH);
    localparam logic [ADDR_W:0]   ONE     = 1;

    state_t            state, stateNext;
    logic [ADDR_W:0]   lenQ, idxQ;
    logic              runQ;
    logic              xfer, wrEn, latchLen, loading;
    logic [WORD_W-1:0] rdData;
`ifdef PROG_LOADER_CSUM_EN
    logic [WORD_W-1:0] sumQ, sumChk;
    assign sumChk = sumQ + bus.in_data;
`endif

    assign xfer = bus.in_valid && bus.in_ready;

    always_comb begin
        stateNext = state;
        wrEn      = 1'b0;
        latchLen  = 1'b0;
        case (state)
            IDLE, RUN, ERR: if (bus.start) stateNext = HDR;
            HDR: if (xfer) stateNext = (bus.in_data == MAGIC) ? LEN : ERR;
            LEN: if (xfer) begin
                if (bus.in_data != '0 && bus.in_data <= DEPTH_W) begin
                    latchLen  = 1'b1;
                    stateNext = DATA;
                end else begin
                    stateNext = ERR;
                end
            end
            DATA: if (xfer) begin
                wrEn = 1'b1;
                if (idxQ == lenQ - ONE) begin
`ifdef PROG_LOADER_CSUM_EN
                    stateNext = CSUM;
`else
                    stateNext = RUN;
`endif
                end
            end
`ifdef PROG_LOADER_CSUM_EN
            CSUM: if (xfer) stateNext = (sumChk == '0) ? RUN : ERR;
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lenQ  <= '0;
            idxQ  <= '0;
            runQ  <= 1'b0;
        end else begin
            state <= stateNext;
            runQ  <= (stateNext == RUN);
            if (latchLen) begin
                lenQ <= bus.in_data[ADDR_W:0];
                idxQ <= '0;
            end else if (wrEn) begin
                idxQ <= idxQ + ONE;
            end
        end
    end

`ifdef PROG_LOADER_CSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sumQ <= '0;
        end else if (latchLen) begin
            sumQ <= '0;
        end else if (wrEn) begin
            sumQ <= sumQ + bus.in_data;
        end
    end
`endif

    always_comb begin
        loading = (state == HDR) || (state == LEN) || (state == DATA);
`ifdef PROG_LOADER_CSUM_EN
        loading = loading || (state == CSUM);
`endif
    end

    prog_mem #(.DEPTH(DEPTH)) u_mem (
        .clk    (clk),
        .wrEn   (wrEn),
        .wrAddr (idxQ[ADDR_W-1:0]),
        .wrData (bus.in_data),
        .rdAddr (bus.cpu_addr),
        .rdData (rdData)
    );

    assign bus.in_ready  = loading;
    assign bus.busy      = loading;
    assign bus.error     = (state == ERR);
    assign bus.cpu_run   = runQ;
    assign bus.cpu_instr = (runQ && ({1'b0, bus.cpu_addr} < lenQ)) ? rdData : '0;
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-cycle vector table plus multi-cycle load sequences.
module tb_prog_loader;
    import prog_loader_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_loader_if bif();

    prog_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    typedef struct {
        bit         st;
        bit         vld;
        logic [7:0] dat;
        logic [3:0] addr;
        bit         rdy;
        bit         bsy;
        bit         err;
        bit         run;
        logic [7:0] instr;
    } vec_t;

    vec_t vt[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(bit st, bit vld, logic [7:0] dat, logic [3:0] addr,
                                bit rdy, bit bsy, bit err, bit run, logic [7:0] instr);
        vec_t v;
        v.st = st; v.vld = vld; v.dat = dat; v.addr = addr;
        v.rdy = rdy; v.bsy = bsy; v.err = err; v.run = run; v.instr = instr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic startPulse;
        bif.start = 1'b1;
        step;
        bif.start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit stall);
        int n;
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                bif.in_valid = 1'b0;
                step;
            end
        end
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        n = 0;
        while (!bif.in_ready && n < 20) begin
            step;
            n++;
        end
        if (!bif.in_ready) chk("xfer_timeout", 0, 1);
        else step;
        bif.in_valid = 1'b0;
    endtask

    // Full image with the correct two's-complement checksum when that byte exists.
    task automatic loadImage(input logic [7:0] img[$], input bit stall);
        logic [7:0] s;
        s = 8'h00;
        startPulse;
        sendByte(MAGIC_DEF, stall);
        sendByte(8'(img.size()), stall);
        foreach (img[i]) begin
            sendByte(img[i], stall);
            s = s + img[i];
        end
`ifdef PROG_LOADER_CSUM_EN
        sendByte(~s + 8'd1, stall);
`endif
    endtask

    task automatic checkMem(input logic [7:0] img[$], input bit running, input string tag);
        logic [7:0] exp;
        for (int a = 0; a < 16; a++) begin
            step;
            bif.cpu_addr = 4'(a);
            #1;
            exp = (running && a < img.size()) ? img[a] : 8'h00;
            chk($sformatf("%s_instr%0d", tag, a), bif.cpu_instr, exp);
        end
    endtask

    task automatic checkStatus(input string tag, input bit rdy, input bit bsy, input bit err, input bit run);
        chk({tag, "_rdy"}, bif.in_ready, rdy);
        chk({tag, "_busy"}, bif.busy, bsy);
        chk({tag, "_err"}, bif.error, err);
        chk({tag, "_run"}, bif.cpu_run, run);
    endtask

    initial begin
        logic [7:0] img[$];
        logic [7:0] s;

        bif.start = 1'b0;
        bif.in_valid = 1'b0;
        bif.in_data = 8'h00;
        bif.cpu_addr = 4'h0;

        #3;
        checkStatus("reset", 0, 0, 0, 0);
        chk("reset_instr", bif.cpu_instr, 8'h00);
        #9 rst_n = 1'b1;

        // Per-cycle vectors: inputs applied before the edge, outputs checked after it.
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00));
        vt.push_back(mk(0, 1, 8'h5A, 0, 0, 0, 1, 0, 8'h00));
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00));
        vt.push_back(mk(0, 1, 8'hA5, 0, 1, 1, 0, 0, 8'h00));
        vt.push_back(mk(0, 1, 8'h00, 0, 0, 0, 1, 0, 8'h00));
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00));
        vt.push_back(mk(0, 1, 8'hA5, 0, 1, 1, 0, 0, 8'h00));
        vt.push_back(mk(0, 1, 8'h11, 0, 0, 0, 1, 0, 8'h00));
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00));
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00));
        vt.push_back(mk(0, 1, 8'hA5, 0, 1, 1, 0, 0, 8'h00));
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00));
        vt.push_back(mk(0, 0, 8'h33, 0, 1, 1, 0, 0, 8'h00));
        vt.push_back(mk(0, 1, 8'h01, 0, 1, 1, 0, 0, 8'h00));
`ifdef PROG_LOADER_CSUM_EN
        vt.push_back(mk(0, 1, 8'h7B, 0, 1, 1, 0, 0, 8'h00));
        vt.push_back(mk(0, 1, 8'h85, 0, 0, 0, 0, 1, 8'h7B));
`else
        vt.push_back(mk(0, 1, 8'h7B, 0, 0, 0, 0, 1, 8'h7B));
`endif
        vt.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0, 1, 8'h00));
        vt.push_back(mk(1, 0, 8'h00, 0, 1, 1, 0, 0, 8'h00));
        vt.push_back(mk(0, 1, 8'h5A, 0, 0, 0, 1, 0, 8'h00));

        for (int i = 0; i < vt.size(); i++) begin
            bif.start    = vt[i].st;
            bif.in_valid = vt[i].vld;
            bif.in_data  = vt[i].dat;
            bif.cpu_addr = vt[i].addr;
            step;
            checkStatus($sformatf("v%0d", i), vt[i].rdy, vt[i].bsy, vt[i].err, vt[i].run);
            chk($sformatf("v%0d_instr", i), bif.cpu_instr, vt[i].instr);
        end
        bif.start = 1'b0;
        bif.in_valid = 1'b0;

        // Three-word image, then reads past the length must return 00.
        img = '{8'h1E, 8'h2F, 8'h3C};
        loadImage(img, 0);
        checkStatus("load3", 0, 0, 0, 1);
        checkMem(img, 1, "load3");

`ifdef PROG_LOADER_CSUM_EN
        startPulse;
        sendByte(8'hA5, 0);
        sendByte(8'h02, 0);
        sendByte(8'h11, 0);
        sendByte(8'h22, 0);
        sendByte(8'h00, 0);
        checkStatus("badcsum", 0, 0, 1, 0);
        img = '{8'h11, 8'h22};
        checkMem(img, 0, "badcsum");
`else
        img = '{8'h11, 8'h22};
        loadImage(img, 0);
        checkStatus("load2", 0, 0, 0, 1);
        checkMem(img, 1, "load2");
`endif

        // Full-depth image with random in_valid gaps.
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(8'($urandom_range(0, 255)));
        loadImage(img, 1);
        checkStatus("load16", 0, 0, 0, 1);
        checkMem(img, 1, "load16");

        // Asynchronous reset in the middle of the data phase.
        startPulse;
        sendByte(8'hA5, 0);
        sendByte(8'h05, 0);
        sendByte(8'h01, 0);
        sendByte(8'h02, 0);
        sendByte(8'h03, 0);
        bif.cpu_addr = 4'h0;
        #2 rst_n = 1'b0;
        #1;
        checkStatus("midrst", 0, 0, 0, 0);
        chk("midrst_instr", bif.cpu_instr, 8'h00);
        step;
        #2 rst_n = 1'b1;
        img = '{8'h91, 8'h82, 8'h73, 8'h64, 8'h55};
        loadImage(img, 0);
        checkStatus("reload", 0, 0, 0, 1);
        checkMem(img, 1, "reload");

        s = 8'h00;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
